// File: rtl/sga_move_unit.sv
// Snake movement stage: button latch, tick-paced head stepping, body shift register and body-memory writeback.
// Define SGA_WRAP_EN to wrap at grid edges instead of treating them as walls.
module sga_move_unit #(
    parameter int TICK_CYCLES = 25_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] buttons,
    input  logic [3:0] size,
    input  logic [3:0] apple,
    output logic [3:0] head,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_data,
    output logic       move_done,
    output logic       apple_eaten,
    output logic       collision,
    output logic [1:0] db_direction,
    output logic [2:0] db_state
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_STEP  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tick;
    logic [3:0]    r_body [16];
    logic [1:0]    r_dir;
    logic [3:0]    r_idx;
    logic          r_hit;
    logic          r_coll;
    logic          r_move_done;
    logic          r_apple_eaten;

    logic [1:0]    w_bdir;
    logic          w_bok;
    logic [3:0]    w_nh;
    logic          w_wall;
    logic          w_self;
    logic [3:0]    w_len;

    assign w_len = (size == 4'd0) ? 4'd1 : size;

    always_comb begin
        w_bdir = r_dir;
        w_bok  = 1'b0;
        case (buttons)
            4'b1000: begin w_bdir = 2'd0; w_bok = 1'b1; end
            4'b0100: begin w_bdir = 2'd1; w_bok = 1'b1; end
            4'b0010: begin w_bdir = 2'd2; w_bok = 1'b1; end
            4'b0001: begin w_bdir = 2'd3; w_bok = 1'b1; end
            default: ;
        endcase
        // Reversal pairs differ only in bit 0 (up/down, left/right)
        if (w_bdir == (r_dir ^ 2'd1)) w_bok = 1'b0;
    end

    always_comb begin
        w_nh   = r_body[0];
        w_wall = 1'b0;
        case (r_dir)
            2'd0: begin
                w_nh[3:2] = r_body[0][3:2] - 2'd1;
                w_wall    = (r_body[0][3:2] == 2'd0);
            end
            2'd1: begin
                w_nh[3:2] = r_body[0][3:2] + 2'd1;
                w_wall    = (r_body[0][3:2] == 2'd3);
            end
            2'd2: begin
                w_nh[1:0] = r_body[0][1:0] - 2'd1;
                w_wall    = (r_body[0][1:0] == 2'd0);
            end
            default: begin
                w_nh[1:0] = r_body[0][1:0] + 2'd1;
                w_wall    = (r_body[0][1:0] == 2'd3);
            end
        endcase
`ifdef SGA_WRAP_EN
        w_wall = 1'b0;
`endif
    end

    // The tail segment body[L-1] moves away this step, so it is excluded
    always_comb begin
        w_self = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(w_len) - 1 && r_body[i] == w_nh) w_self = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tick        <= '0;
            r_body[0]     <= 4'b0101;
            for (int i = 1; i < 16; i++) r_body[i] <= 4'd0;
            r_dir         <= 2'd3;
            r_idx         <= 4'd0;
            r_hit         <= 1'b0;
            r_coll        <= 1'b0;
            r_move_done   <= 1'b0;
            r_apple_eaten <= 1'b0;
        end else begin
            r_move_done   <= 1'b0;
            r_apple_eaten <= 1'b0;
            if (w_bok) r_dir <= w_bdir;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_WAIT;
                        r_coll  <= 1'b0;
                        r_tick  <= '0;
                    end
                end
                S_WAIT: begin
                    if (!start) begin
                        r_state <= S_IDLE;
                        r_tick  <= '0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick  <= '0;
                        r_state <= S_STEP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_STEP: begin
                    if (w_wall || w_self) begin
                        r_coll      <= 1'b1;
                        r_move_done <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        for (int i = 15; i >= 1; i--) r_body[i] <= r_body[i-1];
                        r_body[0] <= w_nh;
                        r_hit     <= (w_nh == apple);
                        r_idx     <= 4'd0;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_idx == w_len - 4'd1) begin
                        r_move_done   <= 1'b1;
                        r_apple_eaten <= r_hit;
                        r_state       <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= (start && !r_coll) ? S_WAIT : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign head         = r_body[0];
    assign mem_we       = (r_state == S_WRITE);
    assign mem_addr     = r_idx;
    assign mem_data     = r_body[r_idx];
    assign move_done    = r_move_done;
    assign apple_eaten  = r_apple_eaten;
    assign collision    = r_coll;
    assign db_direction = r_dir;
    assign db_state     = r_state;
endmodule
